key_scan165: RTL

- Reads a bank of push-buttons through a chain of 74HC165 parallel-in/serial-out shift registers on the same add-on board that carries the 595-driven seven-segment display.
- Generates load and shift-clock strobes, deserialises the chain MSB-first, debounces each key across whole scan frames, and presents a clean level vector plus one-cycle press/release pulses to the host logic.

---
 rtl/key_scan165_pkg.sv | 41 ++++
 rtl/key_scan165_if.sv | 30 +++
 rtl/key_scan165_debounce.sv | 64 ++++++
 rtl/key_scan165.sv | 103 ++++++++++
 4 files changed

// File: rtl/key_scan165_pkg.sv
// key_scan_pkg: shared constants and helpers for the 74HC165 key scanner.
//   DEF_*        default parameter values for the scanner and debouncer
//   FRAME_STEPS  step count of one scan frame at the default chain length
//   STEP_*       fixed step positions inside a frame
//   phase_e      what the 165 control lines do during a given step
package key_scan_pkg;

    localparam int DEF_DIV_W      = 8;
    localparam int DEF_NKEYS      = 16;
    localparam int DEF_DEB_FRAMES = 4;

    localparam int FRAME_STEPS = 2 + 2 * DEF_NKEYS;

    localparam int STEP_LOAD   = 0;
    localparam int STEP_REL    = 1;
    localparam int STEP_SHIFT0 = 2;

    typedef enum logic [1:0] {
        PH_LOAD,
        PH_REL,
        PH_LOW,
        PH_HIGH
    } phase_e;

    function automatic int frame_steps(input int nkeys);
        return 2 + 2 * nkeys;
    endfunction

    // Shift steps alternate clock-low (even) and clock-high (odd).
    function automatic phase_e step_phase(input int step);
        if (step == STEP_LOAD)
            return PH_LOAD;
        else if (step == STEP_REL)
            return PH_REL;
        else if (((step - STEP_SHIFT0) % 2) == 0)
            return PH_LOW;
        else
            return PH_HIGH;
    endfunction

endpackage

// File: rtl/key_scan165_if.sv
// key_scan165_if: board-side 165 chain lines plus host-side key outputs.
//   sh_ld_n, sh_clk   165 SH/LD and CLK strobes
//   ser_in            QH of the chip nearest the FPGA
//   keys              debounced levels, 1 = pressed
//   key_down/key_up   one-cycle press/release pulses
//   frame_tick        one-cycle pulse per committed raw frame
// master = scanner, slave = board/host side.
interface key_scan165_if
    import key_scan_pkg::*;
#(
    parameter int NKEYS = DEF_NKEYS
);
    logic             sh_ld_n;
    logic             sh_clk;
    logic             ser_in;
    logic [NKEYS-1:0] keys;
    logic [NKEYS-1:0] key_down;
    logic [NKEYS-1:0] key_up;
    logic             frame_tick;

    modport master (
        output sh_ld_n, sh_clk, keys, key_down, key_up, frame_tick,
        input  ser_in
    );

    modport slave (
        input  sh_ld_n, sh_clk, keys, key_down, key_up, frame_tick,
        output ser_in
    );
endinterface

// File: rtl/key_scan165_debounce.sv
// key_debounce: frame-based debouncer.
//   frame     pressed-sense raw frame (1 = pressed)
//   push      one-cycle strobe: shift frame into the history
//   keys      debounced levels
//   key_down  pulse on debounced 0->1, key_up pulse on debounced 1->0
// A key changes level only when every history entry agrees.
module key_debounce
    import key_scan_pkg::*;
#(
    parameter int NKEYS      = DEF_NKEYS,
    parameter int DEB_FRAMES = DEF_DEB_FRAMES
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [NKEYS-1:0] frame,
    input  logic             push,
    output logic [NKEYS-1:0] keys,
    output logic [NKEYS-1:0] key_down,
    output logic [NKEYS-1:0] key_up
);

    // History is held in wire polarity so the all-ones reset means released.
    logic [NKEYS-1:0] hist_n [DEB_FRAMES];
    logic             vld_p0;
    logic [NKEYS-1:0] all_on;
    logic [NKEYS-1:0] all_off;

    always_comb begin
        all_on  = '1;
        all_off = '1;
        for (int d = 0; d < DEB_FRAMES; d++) begin
            all_on  = all_on & ~hist_n[d];
            all_off = all_off & hist_n[d];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int d = 0; d < DEB_FRAMES; d++)
                hist_n[d] <= '1;
            vld_p0   <= 1'b0;
            keys     <= '0;
            key_down <= '0;
            key_up   <= '0;
        end else begin
            // p0: history push
            vld_p0 <= push;
            if (push) begin
                hist_n[0] <= ~frame;
                for (int d = 1; d < DEB_FRAMES; d++)
                    hist_n[d] <= hist_n[d-1];
            end
            // p1: level decision on the freshly pushed history
            key_down <= '0;
            key_up   <= '0;
            if (vld_p0) begin
                key_down <= all_on & ~keys;
                key_up   <= all_off & keys;
                keys     <= (keys | all_on) & ~all_off;
            end
        end
    end

endmodule

// File: rtl/key_scan165.sv
// key_scan165: scans a 74HC165 key chain and debounces it.
//   sys_clk, sys_rst_n  clock and asynchronous active-low reset
//   bus (master)        sh_ld_n/sh_clk strobes, ser_in, keys,
//                       key_down/key_up pulses, frame_tick
// A prescaler tick advances a step counter through load, release and
// NKEYS clock-low/clock-high pairs. The counter holds the step that the
// next tick enters, so control outputs are registered from it directly.
module key_scan165
    import key_scan_pkg::*;
#(
    parameter int DIV_W      = DEF_DIV_W,
    parameter int NKEYS      = DEF_NKEYS,
    parameter int DEB_FRAMES = DEF_DEB_FRAMES
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    key_scan165_if.master bus
);

    localparam int N_STEPS = frame_steps(NKEYS);
    localparam int SW      = $clog2(N_STEPS);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [SW-1:0]    step;
    logic             primed;
    phase_e           ph;
    logic             ser_p0;
    logic             ser_p1;
    logic [NKEYS-1:0] raw;
    logic             sample;
    logic             push;
    logic             sh_ld_n_r;
    logic             sh_clk_r;
    logic             frame_tick_r;
    logic [NKEYS-1:0] keys_w;
    logic [NKEYS-1:0] down_w;
    logic [NKEYS-1:0] up_w;

    assign tick = &div_cnt;
    assign ph   = step_phase(int'(step));

    // Entering a clock-high step is the tick leaving its clock-low step:
    // QH has settled for a full step and the chain has not yet shifted.
    assign sample = tick && (ph == PH_HIGH);

    // Entering a load after at least one full frame commits that frame.
    // primed keeps the very first load after reset from committing.
    assign push = tick && primed && (ph == PH_LOAD);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt      <= '0;
            step         <= '0;
            primed       <= 1'b0;
            ser_p0       <= 1'b0;
            ser_p1       <= 1'b0;
            raw          <= '0;
            sh_ld_n_r    <= 1'b1;
            sh_clk_r     <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            // p0/p1: ser_in synchroniser
            ser_p0 <= bus.ser_in;
            ser_p1 <= ser_p0;

            div_cnt      <= div_cnt + 1'b1;
            frame_tick_r <= push;

            if (tick) begin
                step      <= (step == SW'(N_STEPS - 1)) ? '0 : step + 1'b1;
                primed    <= 1'b1;
                sh_ld_n_r <= (ph != PH_LOAD);
                sh_clk_r  <= (ph == PH_HIGH);
            end

            if (sample)
                raw <= {raw[NKEYS-2:0], ser_p1};
        end
    end

    // Board pull-ups: a pressed key reads 0 on the wire.
    key_debounce #(
        .NKEYS      (NKEYS),
        .DEB_FRAMES (DEB_FRAMES)
    ) u_debounce (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .frame     (~raw),
        .push      (push),
        .keys      (keys_w),
        .key_down  (down_w),
        .key_up    (up_w)
    );

    assign bus.sh_ld_n    = sh_ld_n_r;
    assign bus.sh_clk     = sh_clk_r;
    assign bus.frame_tick = frame_tick_r;
    assign bus.keys       = keys_w;
    assign bus.key_down   = down_w;
    assign bus.key_up     = up_w;

endmodule
